// File: rtl/tristate_bus_mux.sv
// Tristate bus multiplexer: drives one of NCH channels onto a shared bus and
// inserts a TA_CYCLES high-Z turnaround gap whenever the driving channel changes.
module tristate_bus_mux #(
    parameter int WIDTH     = 8,
    parameter int NCH       = 4,
    parameter int TA_CYCLES = 1,
    localparam int SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SELW-1:0]      sel,
    input  logic                 sel_valid,
    output logic                 sel_ready,
    input  logic                 rel,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_oe,
    output logic [SELW-1:0]      cur_sel,
    output logic                 sel_err
);

    localparam int CNTW = 4;

    generate
        if (NCH < 2 || NCH > 16) begin : g_bad_nch
            $error("tristate_bus_mux: NCH must be in 2..16");
        end
        if (TA_CYCLES < 1 || TA_CYCLES > 15) begin : g_bad_ta
            $error("tristate_bus_mux: TA_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [CNTW-1:0]  cnt_q;

    logic [WIDTH-1:0] din_req;
    logic [WIDTH-1:0] din_cur;
    logic             sel_in_range;
    logic             req_fire;
    logic             accept;
    logic             req_bad;

    // Channel data for the requested and the currently owned channel.
    always_comb begin
        din_req = '0;
        din_cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i)) begin
                din_req = din[i*WIDTH +: WIDTH];
            end
            if (cur_sel == SELW'(i)) begin
                din_cur = din[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_in_range = ({1'b0, sel} < (SELW+1)'(NCH));
    assign sel_ready    = rst_n && !rel && (state_q != StTurn);
    assign req_fire     = sel_valid && sel_ready;
    assign accept       = req_fire && sel_in_range;
    assign req_bad      = req_fire && !sel_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            bus_oe  <= 1'b0;
            cur_sel <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= req_bad;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StDrive;
                        cur_sel <= sel;
                        data_q  <= din_req;
                        bus_oe  <= 1'b1;
                    end
                end
                StDrive: begin
                    if (rel) begin
                        state_q <= StIdle;
                        bus_oe  <= 1'b0;
                    end else if (accept && (sel != cur_sel)) begin
                        // Drop the bus now; the new owner drives after the gap.
                        state_q <= StTurn;
                        cur_sel <= sel;
                        cnt_q   <= CNTW'(TA_CYCLES - 1);
                        bus_oe  <= 1'b0;
                    end else begin
                        data_q  <= din_cur;
                    end
                end
                StTurn: begin
                    if (rel) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        bus_oe  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= StDrive;
                        data_q  <= din_cur;
                        bus_oe  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - CNTW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    bus_oe  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_out = bus_oe ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_mux.sv
// Scoreboard bench for tristate_bus_mux (NCH=3, TA_CYCLES=2): a driver pushes
// model predictions per cycle, a monitor pops and compares at the falling edge.
module tb_tristate_bus_mux;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int TA = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*W-1:0] din;
    logic [SW-1:0] sel;
    logic          sel_valid;
    logic          sel_ready;
    logic          rel;
    logic [W-1:0]  bus_out;
    logic          bus_oe;
    logic [SW-1:0] cur_sel;
    logic          sel_err;

    always #5 clk = ~clk;

    tristate_bus_mux #(
        .WIDTH    (W),
        .NCH      (N),
        .TA_CYCLES(TA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .sel      (sel),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .rel      (rel),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .cur_sel  (cur_sel),
        .sel_err  (sel_err)
    );

    typedef struct {
        logic          ready;
        logic          oe;
        logic [W-1:0]  bus;
        logic [SW-1:0] cur;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the bus, how many gap cycles remain.
    bit           m_drv;
    int           m_gap;
    int           m_ch;
    logic [W-1:0] m_data;
    bit           m_err;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_drv  = 1'b0;
        m_gap  = 0;
        m_ch   = 0;
        m_data = '0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input int s, input bit r,
                                       input logic [N*W-1:0] d);
        bit ready;
        ready = !r && (m_gap == 0);
        m_err = 1'b0;
        if (r && (m_drv || m_gap > 0)) begin
            m_drv = 1'b0;
            m_gap = 0;
        end else if (v && ready) begin
            if (s >= N) begin
                m_err = 1'b1;
            end else if (!m_drv) begin
                m_drv = 1'b1;
                m_ch  = s;
            end else if (s != m_ch) begin
                m_drv = 1'b0;
                m_gap = TA;
                m_ch  = s;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_drv = 1'b1;
        end
        if (m_drv) m_data = d[m_ch*W +: W];
    endfunction

    function automatic logic [N*W-1:0] mkdin(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                             input logic [W-1:0] c2);
        return {c2, c1, c0};
    endfunction

    // One clock of stimulus: predict what the DUT shows now, then advance the model.
    task automatic cycle(input bit v, input int s, input bit r, input logic [N*W-1:0] d);
        exp_t e;
        @(posedge clk);
        #2;
        sel_valid = v;
        sel       = SW'(s);
        rel       = r;
        din       = d;
        e.ready   = !r && (m_gap == 0);
        e.oe      = m_drv;
        e.bus     = m_drv ? m_data : {W{1'bz}};
        e.cur     = SW'(m_ch);
        e.err     = m_err;
        sb.push_back(e);
        model_step(v, s, r, d);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 0, 1'b0, (N*W)'($urandom));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_oe"}, bus_oe, 1'b0);
        chk({tag, "_bus"}, bus_out, {W{1'bz}});
        chk({tag, "_cur"}, cur_sel, '0);
        chk({tag, "_err"}, sel_err, 1'b0);
        chk({tag, "_ready"}, sel_ready, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        rel       = 1'b0;
        sel       = '0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sel_ready", sel_ready, e.ready);
                chk("bus_oe", bus_oe, e.oe);
                chk("bus_out", bus_out, e.bus);
                chk("cur_sel", cur_sel, e.cur);
                chk("sel_err", sel_err, e.err);
            end
        end
    end

    initial begin : driver
        rst_n     = 1'b1;
        sel_valid = 1'b0;
        sel       = '0;
        rel       = 1'b0;
        din       = '0;
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Basic drive of ch2 and one-cycle data latency.
        cycle(1'b1, 2, 1'b0, mkdin(8'h11, 8'h22, 8'hA5));
        cycle(1'b0, 0, 1'b0, mkdin(8'h11, 8'h22, 8'hA5));
        cycle(1'b0, 0, 1'b0, mkdin(8'h11, 8'h22, 8'h3C));
        cycle(1'b0, 0, 1'b0, mkdin(8'h11, 8'h22, 8'h3C));
        idle_cycles(1);

        // Switch ch2 -> ch1: two-cycle Z gap, not ready during it.
        cycle(1'b1, 1, 1'b0, (N*W)'($urandom));
        cycle(1'b1, 0, 1'b0, (N*W)'($urandom));
        idle_cycles(3);

        // Re-request the owning channel: no gap.
        cycle(1'b1, 1, 1'b0, (N*W)'($urandom));
        cycle(1'b1, 1, 1'b0, (N*W)'($urandom));
        idle_cycles(2);

        // Release wins over a simultaneous request.
        cycle(1'b1, 3, 1'b1, (N*W)'($urandom));
        idle_cycles(2);
        cycle(1'b0, 0, 1'b1, (N*W)'($urandom));

        // Out-of-range select in idle.
        cycle(1'b1, 3, 1'b0, (N*W)'($urandom));
        idle_cycles(2);

        // Reset in the middle of a turnaround, then a fresh request for ch0.
        cycle(1'b1, 2, 1'b0, (N*W)'($urandom));
        idle_cycles(1);
        cycle(1'b1, 0, 1'b0, (N*W)'($urandom));
        async_reset("mid_turn");
        cycle(1'b1, 0, 1'b0, (N*W)'($urandom));
        idle_cycles(2);

        // Randomized traffic with occasional releases and one async reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_reset("rand_reset");
            end
            cycle(($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), (N*W)'($urandom));
        end
        idle_cycles(1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tristate_bus_mux.md
TRISTATE_BUS_MUX -- requirements
Module: tristate_bus_mux

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel and bus width.
REQ-002 Parameter NCH, default 4: number of input channels; legal range 2..16.
REQ-003 Parameter TA_CYCLES, default 1: bus turnaround gap in cycles when switching channel; legal range 1..15.
REQ-004 Derived SELW = ceil(log2(NCH)); not user-overridable.
REQ-005 Interface: one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 din  input  NCH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 sel  input  SELW  requested channel index.
REQ-010 sel_valid  input  1  request to drive channel sel.
REQ-011 sel_ready  output  1  request accepted on a clock edge where sel_valid && sel_ready.
REQ-012 rel  input  1  release the bus (return to high-Z).
REQ-013 bus_out  output  WIDTH  tristate bus: registered channel data when bus_oe=1, all-Z otherwise.
REQ-014 bus_oe  output  1  registered output-enable; high only in DRIVE.
REQ-015 cur_sel  output  SELW  channel currently driven or pending.
REQ-016 sel_err  output  1  one-cycle pulse: out-of-range sel was presented.

Function
REQ-017 The block SHALL implement states IDLE, DRIVE, TURN.
REQ-018 sel_ready SHALL be 1 in IDLE and DRIVE when rel=0, and 0 in TURN or when rel=1.
REQ-019 Accept = sel_valid && sel_ready && (sel < NCH); sel_valid && sel_ready && (sel >= NCH) SHALL pulse sel_err next cycle with no state/cur_sel change.
REQ-020 IDLE + accept: next state DRIVE, cur_sel <= sel, data reg <= din[sel] at same edge.
REQ-021 DRIVE: data reg SHALL load din[cur_sel] every edge; bus_out shows din sampled at the previous edge (latency 1 cycle).
REQ-022 DRIVE + accept with sel == cur_sel: stay DRIVE, no gap, bus_oe stays 1.
REQ-023 DRIVE + accept with sel != cur_sel: next state TURN, cur_sel <= sel, turnaround counter <= TA_CYCLES-1, bus_oe <= 0.
REQ-024 TURN: counter decrements each cycle; at count 0 the next state is DRIVE with data reg <= din[cur_sel]; bus is Z for exactly TA_CYCLES cycles.
REQ-025 rel=1 in DRIVE or TURN: next state IDLE, bus_oe <= 0; rel has priority over any concurrent sel_valid.
REQ-026 rel=1 in IDLE: no effect.
REQ-027 bus_out SHALL never be driven in IDLE or TURN; no cycle shall drive two different channels' data without an intervening Z gap.
REQ-028 cur_sel SHALL hold its value in IDLE after release.

Reset
REQ-029 rst_n=0 SHALL immediately (no clock) force state IDLE, bus_oe=0, bus_out all-Z, cur_sel=0, data reg=0, counter=0, sel_err=0.
REQ-030 Reset asserted mid-DRIVE or mid-TURN SHALL abort with no further drive; after deassertion the first accept SHALL behave as from IDLE.
REQ-031 sel_ready SHALL be 0 while rst_n=0.

Verification
REQ-032 Reset, then sel=2, sel_valid=1 one cycle, din ch2=8'hA5 -> bus_oe=1 next cycle, bus_out=8'hA5; later din ch2=8'h3C -> bus_out=8'h3C one cycle after.
REQ-033 DRIVE ch2, request sel=1 with TA_CYCLES=2 -> bus_out Z for exactly 2 cycles, then ch1 data; sel_ready=0 during the gap.
REQ-034 DRIVE ch1, request sel=1 again -> no Z gap, bus_oe stays 1 continuously.
REQ-035 DRIVE, rel=1 and sel_valid=1 (sel=3) same cycle -> IDLE, bus Z, cur_sel unchanged, request not accepted.
REQ-036 NCH=3, sel=3 with sel_valid=1 in IDLE -> sel_err=1 for one cycle, bus stays Z, state IDLE.
REQ-037 rst_n low mid-TURN without clock edge -> bus_oe=0 and bus_out Z immediately; after release, sel=0 request drives ch0 next cycle.
